eth_10g_pcs_tx: RTL and testbench

Transmit-side 64b/66b PCS for the 10G Ethernet path. It accepts 66-bit blocks (64-bit payload plus 2-bit sync header) over an AXI-Stream-style handshake and scrambles the payload with the self-synchronous x^58+x^39+1 scrambler. It splits each block into two 32-bit words and drives the GTX TX external-gearbox interface (TXDATA, TXHEADER, TXSEQUENCE). It sits between the MAC/encoder and the GTX lane, in the TXUSRCLK2 domain.

---
 rtl/eth_10g_pcs_tx_if.sv | 22 ++
 rtl/eth_10g_pcs_tx.sv | 108 ++++++++++
 tb/tb_eth_10g_pcs_tx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_10g_pcs_tx_if.sv
// Upstream block stream into the 10G PCS transmitter: a 66-bit block
// (64-bit payload plus 2-bit sync header) with a valid/ready handshake.
interface eth_10g_pcs_tx_if;
  logic        i_s_axis_tvalid;
  logic        o_s_axis_tready;
  logic [63:0] i_s_axis_tdata;
  logic [1:0]  i_s_axis_tuser;

  modport master (
    output i_s_axis_tvalid,
    output i_s_axis_tdata,
    output i_s_axis_tuser,
    input  o_s_axis_tready
  );

  modport slave (
    input  i_s_axis_tvalid,
    input  i_s_axis_tdata,
    input  i_s_axis_tuser,
    output o_s_axis_tready
  );
endinterface

// File: rtl/eth_10g_pcs_tx.sv
// 64b/66b PCS transmitter: scrambles 64-bit payloads with x^58+x^39+1 and
// feeds the GTX external gearbox as two 32-bit words per block, following a
// 33-cycle TXSEQUENCE period (16 blocks, one pause cycle at sequence 32).
module eth_10g_pcs_tx (
  input  logic                     i_clk,
  input  logic                     i_rst,
  eth_10g_pcs_tx_if.slave          s_axis,
  output logic [31:0]              o_txdata,
  output logic [1:0]               o_txheader,
  output logic [6:0]               o_txsequence,
  output logic                     o_idle_inserted,
  output logic                     o_bad_header
);

  localparam logic [63:0] IDLE_DATA = 64'h0000_0000_0000_001E;
  localparam logic [1:0]  IDLE_HDR  = 2'b10;
  localparam logic [6:0]  SEQ_LAST  = 7'd32;

  logic [6:0]   seq_q, seq_d;
  logic [57:0]  scr_q, scr_d;
  logic [31:0]  hi_q, hi_d;
  logic [31:0]  txdata_q, txdata_d;
  logic [1:0]   txheader_q, txheader_d;
  logic         idle_q, idle_d;
  logic         bad_q, bad_d;

  logic         slot;
  logic [63:0]  blk_data;
  logic [1:0]   blk_hdr;
  logic [63:0]  blk_scr;
  logic [121:0] ext;

  // A block is loaded when the next sequence value is an even slot below 32,
  // i.e. in the pause cycle or in odd cycles other than 31.
  assign slot = (seq_q == SEQ_LAST) || (seq_q[0] && (seq_q != 7'd31));
  assign s_axis.o_s_axis_tready = !i_rst && slot;

  // Pick the input block, or an idle control block when upstream has nothing.
  always_comb begin
    blk_data = IDLE_DATA;
    blk_hdr  = IDLE_HDR;
    if (s_axis.i_s_axis_tvalid) begin
      blk_data = s_axis.i_s_axis_tdata;
      blk_hdr  = s_axis.i_s_axis_tuser;
    end
  end

  // Self-synchronous scrambler: ext[57:0] is the previous 58 scrambled bits
  // (oldest at index 0), ext[121:58] receives this block, LSB first.
  always_comb begin
    ext = {64'd0, scr_q};
    for (int i = 0; i < 64; i++) begin
      ext[i+58] = blk_data[i] ^ ext[i+19] ^ ext[i];
    end
    blk_scr = ext[121:58];
  end

  // Sequence, scrambler state and gearbox word selection.
  always_comb begin
    seq_d      = (seq_q == SEQ_LAST) ? 7'd0 : seq_q + 7'd1;
    scr_d      = scr_q;
    hi_d       = hi_q;
    txdata_d   = txdata_q;
    txheader_d = txheader_q;
    idle_d     = 1'b0;
    bad_d      = 1'b0;
    if (slot) begin
      scr_d      = blk_scr[63:6];
      hi_d       = blk_scr[63:32];
      txdata_d   = blk_scr[31:0];
      txheader_d = blk_hdr;
      idle_d     = !s_axis.i_s_axis_tvalid;
      bad_d      = s_axis.i_s_axis_tvalid &&
                   ((s_axis.i_s_axis_tuser == 2'b00) || (s_axis.i_s_axis_tuser == 2'b11));
    end else if (!seq_q[0] && (seq_q != SEQ_LAST)) begin
      // Low word is on the wire now; the upper half follows next cycle.
      txdata_d = hi_q;
    end
  end

  // State registers; reset drops any half-sent block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seq_q      <= SEQ_LAST;
      scr_q      <= '1;
      hi_q       <= '0;
      txdata_q   <= '0;
      txheader_q <= 2'b00;
      idle_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      scr_q      <= scr_d;
      hi_q       <= hi_d;
      txdata_q   <= txdata_d;
      txheader_q <= txheader_d;
      idle_q     <= idle_d;
      bad_q      <= bad_d;
    end
  end

  assign o_txdata        = txdata_q;
  assign o_txheader      = txheader_q;
  assign o_txsequence    = seq_q;
  assign o_idle_inserted = idle_q;
  assign o_bad_header    = bad_q;

endmodule

// File: tb/tb_eth_10g_pcs_tx.sv
// Bench for eth_10g_pcs_tx: a hand-computed vector table for reset, the
// zero-block scrambler result, bad header and mid-block reset, then
// sequences checked by an independent descrambler and block scoreboard.
module tb_eth_10g_pcs_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] o_txdata;
  logic [1:0]  o_txheader;
  logic [6:0]  o_txsequence;
  logic        o_idle_inserted;
  logic        o_bad_header;

  eth_10g_pcs_tx_if axis ();

  eth_10g_pcs_tx dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .s_axis          (axis.slave),
    .o_txdata        (o_txdata),
    .o_txheader      (o_txheader),
    .o_txsequence    (o_txsequence),
    .o_idle_inserted (o_idle_inserted),
    .o_bad_header    (o_bad_header)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        v;
    logic [1:0]  u;
    logic [63:0] d;
    logic        rdy;
    logic [6:0]  seq;
    logic [1:0]  hdr;
    logic [31:0] dat;
    logic        chkdat;
    logic        idle;
    logic        bd;
  } vec_t;

  typedef struct {
    logic [1:0]  h;
    logic [63:0] d;
  } blk_t;

  vec_t        tbl[11];
  blk_t        expq[$];
  logic [6:0]  mseq;
  logic        exp_idle_n, exp_bad_n;
  logic        have_lo;
  logic [31:0] rx_lo;
  logic [1:0]  rx_hdr;
  logic [57:0] ds;
  int          idle_cnt, rdy_cnt, acc_cnt;

  // Descramble one received block and compare against the oldest expected block.
  task automatic receive(input logic [63:0] s);
    logic [121:0] e;
    logic [63:0]  dd;
    blk_t         x;
    e = {s, ds};
    for (int i = 0; i < 64; i++) dd[i] = e[i+58] ^ e[i+19] ^ e[i];
    ds = s[63:6];
    if (expq.size() == 0) begin
      chk("scoreboard_underflow", 64'd1, 64'd0);
    end else begin
      x = expq.pop_front();
      chk("rx_header", 64'(rx_hdr), 64'(x.h));
      chk("rx_payload", dd, x.d);
    end
  endtask

  // One cycle: drive inputs, check against the model, advance the clock.
  task automatic cyc(input logic v, input logic [1:0] u, input logic [63:0] d);
    logic exp_rdy;
    axis.i_s_axis_tvalid = v;
    axis.i_s_axis_tuser  = u;
    axis.i_s_axis_tdata  = d;
    #1;
    exp_rdy = (mseq == 7'd32) || (mseq[0] && mseq != 7'd31);
    chk("seq", 64'(o_txsequence), 64'(mseq));
    chk("tready", 64'(axis.o_s_axis_tready), 64'(exp_rdy));
    chk("idle_pulse", 64'(o_idle_inserted), 64'(exp_idle_n));
    chk("bad_pulse", 64'(o_bad_header), 64'(exp_bad_n));
    if (o_idle_inserted) idle_cnt++;
    if (exp_rdy) rdy_cnt++;
    if (mseq < 7'd32 && !mseq[0]) begin
      rx_lo = o_txdata; rx_hdr = o_txheader; have_lo = 1'b1;
    end else if (mseq < 7'd32 && have_lo) begin
      receive({o_txdata, rx_lo});
      have_lo = 1'b0;
    end
    exp_idle_n = 1'b0;
    exp_bad_n  = 1'b0;
    if (exp_rdy) begin
      if (v) begin
        expq.push_back('{u, d});
        exp_bad_n = (u == 2'b00) || (u == 2'b11);
        acc_cnt++;
      end else begin
        expq.push_back('{2'b10, 64'h1E});
        exp_idle_n = 1'b1;
      end
    end
    mseq = (mseq == 7'd32) ? 7'd0 : mseq + 7'd1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    chk("inflight_before_reset", 64'(expq.size() > 1), 64'd0);
    rst = 1'b1;
    axis.i_s_axis_tvalid = 1'b0;
    #1;
    chk("tready_in_reset", 64'(axis.o_s_axis_tready), 64'd0);
    @(posedge clk); #1;
    chk("rst_seq", 64'(o_txsequence), 64'd32);
    chk("rst_txdata", 64'(o_txdata), 64'd0);
    chk("rst_txheader", 64'(o_txheader), 64'd0);
    chk("rst_pulses", 64'({o_idle_inserted, o_bad_header}), 64'd0);
    chk("tready_held_reset", 64'(axis.o_s_axis_tready), 64'd0);
    rst = 1'b0;
    mseq = 7'd32; exp_idle_n = 1'b0; exp_bad_n = 1'b0;
    have_lo = 1'b0; ds = '1;
    expq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    //          rst   v     u      d               rdy   seq    hdr    dat            chk   idle  bd
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 64'h0,          1'b0, 7'd32, 2'b00, 32'h0,         1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'b01, 64'h0,          1'b1, 7'd32, 2'b00, 32'h0,         1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 2'b11, 64'hDEAD_BEEF,  1'b0, 7'd0,  2'b01, 32'h0,         1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 2'b11, 64'h0,          1'b1, 7'd1,  2'b01, 32'h03FF_FF80, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'b00, 64'h0,          1'b0, 7'd2,  2'b11, 32'hFFFF_C000, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 2'b00, 64'h0,          1'b1, 7'd3,  2'b11, 32'hFFEF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'b00, 64'h0,          1'b0, 7'd4,  2'b10, 32'h0,         1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 2'b01, 64'h0,          1'b0, 7'd32, 2'b00, 32'h0,         1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 2'b01, 64'h0,          1'b1, 7'd32, 2'b00, 32'h0,         1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'b00, 64'h0,          1'b0, 7'd0,  2'b01, 32'h0,         1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'b00, 64'h0,          1'b1, 7'd1,  2'b01, 32'h03FF_FF80, 1'b1, 1'b0, 1'b0};

    axis.i_s_axis_tvalid = 1'b0;
    axis.i_s_axis_tuser  = 2'b00;
    axis.i_s_axis_tdata  = 64'h0;
    mseq = 7'd32; exp_idle_n = 1'b0; exp_bad_n = 1'b0;
    have_lo = 1'b0; ds = '1; rx_lo = '0; rx_hdr = '0;
    idle_cnt = 0; rdy_cnt = 0; acc_cnt = 0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst;
      axis.i_s_axis_tvalid = tbl[i].v;
      axis.i_s_axis_tuser  = tbl[i].u;
      axis.i_s_axis_tdata  = tbl[i].d;
      #1;
      chk($sformatf("vec%0d_tready", i), 64'(axis.o_s_axis_tready), 64'(tbl[i].rdy));
      chk($sformatf("vec%0d_seq", i), 64'(o_txsequence), 64'(tbl[i].seq));
      chk($sformatf("vec%0d_hdr", i), 64'(o_txheader), 64'(tbl[i].hdr));
      if (tbl[i].chkdat) chk($sformatf("vec%0d_data", i), 64'(o_txdata), 64'(tbl[i].dat));
      chk($sformatf("vec%0d_idle", i), 64'(o_idle_inserted), 64'(tbl[i].idle));
      chk($sformatf("vec%0d_bad", i), 64'(o_bad_header), 64'(tbl[i].bd));
      @(posedge clk); #1;
    end

    // Idle run: every slot filled with an inserted idle block.
    do_reset();
    idle_cnt = 0; rdy_cnt = 0;
    repeat (66) cyc(1'b0, 2'b00, 64'h0);
    chk("idle_run_pulses", 64'(idle_cnt), 64'd32);
    chk("idle_run_ready", 64'(rdy_cnt), 64'd32);

    // Continuous stream of random data blocks.
    do_reset();
    idle_cnt = 0; rdy_cnt = 0; acc_cnt = 0;
    repeat (33) cyc(1'b1, 2'b01, {$urandom, $urandom});
    chk("stream_duty", 64'(rdy_cnt), 64'd16);
    for (int n = 0; n < 600 && acc_cnt < 200; n++) cyc(1'b1, 2'b01, {$urandom, $urandom});
    chk("stream_accepted", 64'(acc_cnt), 64'd200);
    chk("stream_no_idle", 64'(idle_cnt), 64'd0);

    // Random tvalid gaps with a mix of data and control headers.
    for (int n = 0; n < 300; n++)
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, {$urandom, $urandom});

    // Reset while the sequence is mid-period, then the zero-block check again.
    for (int n = 0; n < 40 && mseq != 7'd15; n++) cyc(1'b1, 2'b01, {$urandom, $urandom});
    chk("reached_seq15", 64'(mseq), 64'd15);
    do_reset();
    cyc(1'b1, 2'b01, 64'h0);
    chk("rerst_low_hdr", 64'(o_txheader), 64'd1);
    chk("rerst_low_data", 64'(o_txdata), 64'd0);
    cyc(1'b0, 2'b00, 64'h0);
    chk("rerst_high_data", 64'(o_txdata), 64'h03FF_FF80);
    cyc(1'b0, 2'b00, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
